// File: rtl/fir_l2_pkg.sv
// Shared definitions for the L=2 parallel FIR and its input packer.
package fir_l2_pkg;

  // Sample width shared by the packer and the FIR top.
  localparam int unsigned FIR_DATA_IN_WIDTH = 16;

  // Packer state: whether an even sample is currently held.
  typedef enum logic {
    PACK_IDLE,
    PACK_HALF
  } pack_state_t;

endpackage

// File: rtl/fir_l2_input_pack.sv
// Serial-to-pair input stage for the L=2 parallel FIR.
// Packs consecutive samples into (even, odd) pairs on a registered two-lane output.
// Optional feature: define FIR_L2_PACK_FLUSH_EN to add a `flush` input that emits a
// pending half-pair as (even, 0).
module fir_l2_input_pack
  import fir_l2_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH = FIR_DATA_IN_WIDTH,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic signed [DATA_IN_WIDTH-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic signed [DATA_IN_WIDTH-1:0] m_data_1,
  output logic signed [DATA_IN_WIDTH-1:0] m_data_2,
  output logic                            m_valid,
  input  logic                            m_ready,
`ifdef FIR_L2_PACK_FLUSH_EN
  input  logic                            flush,
`endif
  output logic [CNT_WIDTH-1:0]            pair_count
);

  pack_state_t                     state_q, state_d;
  logic signed [DATA_IN_WIDTH-1:0] even_q, even_d;
  logic signed [DATA_IN_WIDTH-1:0] data_1_q, data_1_d;
  logic signed [DATA_IN_WIDTH-1:0] data_2_q, data_2_d;
  logic                            valid_q, valid_d;
  logic [CNT_WIDTH-1:0]            count_q, count_d;

  logic out_free;
  logic in_xfer;
  logic out_xfer;
  logic do_flush;

  // Output slot can take a new pair when empty or being drained this cycle.
  always_comb begin
    out_free = !valid_q || m_ready;
    s_ready  = (state_q == PACK_IDLE) ? 1'b1 : out_free;
    in_xfer  = s_valid && s_ready;
    out_xfer = valid_q && m_ready;
  end

  // Flush only matters in PACK_HALF with no odd sample arriving; the input wins.
`ifdef FIR_L2_PACK_FLUSH_EN
  always_comb begin
    do_flush = flush && (state_q == PACK_HALF) && !in_xfer && out_free;
  end
`else
  always_comb begin
    do_flush = 1'b0;
  end
`endif

  // Next-state: pairing FSM, output register and hand-off counter.
  always_comb begin
    state_d  = state_q;
    even_d   = even_q;
    data_1_d = data_1_q;
    data_2_d = data_2_q;
    valid_d  = valid_q && !out_xfer;
    count_d  = out_xfer ? count_q + CNT_WIDTH'(1) : count_q;

    unique case (state_q)
      PACK_IDLE: begin
        if (in_xfer) begin
          even_d  = s_data;
          state_d = PACK_HALF;
        end
      end
      PACK_HALF: begin
        if (in_xfer) begin
          data_1_d = even_q;
          data_2_d = s_data;
          valid_d  = 1'b1;
          state_d  = PACK_IDLE;
        end else if (do_flush) begin
          data_1_d = even_q;
          data_2_d = '0;
          valid_d  = 1'b1;
          state_d  = PACK_IDLE;
        end
      end
      default: state_d = PACK_IDLE;
    endcase
  end

  // State registers; reset discards any held sample and pending pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PACK_IDLE;
      even_q   <= '0;
      data_1_q <= '0;
      data_2_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      even_q   <= even_d;
      data_1_q <= data_1_d;
      data_2_q <= data_2_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign m_data_1   = data_1_q;
  assign m_data_2   = data_2_q;
  assign m_valid    = valid_q;
  assign pair_count = count_q;

endmodule

// File: tb/tb_fir_l2_input_pack.sv
// Directed self-checking bench for fir_l2_input_pack.
// The pair counter is instantiated 8 bits wide so its wrap is reachable in a short run.
module tb_fir_l2_input_pack;

  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 8;

  logic             clk;
  logic             reset_n;
  logic [DataW-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DataW-1:0] m_data_1;
  logic [DataW-1:0] m_data_2;
  logic             m_valid;
  logic             m_ready;
  logic [CntW-1:0]  pair_count;
`ifdef FIR_L2_PACK_FLUSH_EN
  logic             flush;
`endif

  int n_checks;
  int n_fails;

  fir_l2_input_pack #(
    .DATA_IN_WIDTH (DataW),
    .CNT_WIDTH     (CntW)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data_1   (m_data_1),
    .m_data_2   (m_data_2),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIR_L2_PACK_FLUSH_EN
    .flush      (flush),
`endif
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer two samples back-to-back; leaves s_valid low afterwards.
  task automatic send_pair(input logic [DataW-1:0] a, input logic [DataW-1:0] b);
    s_valid = 1'b1;
    s_data  = a;
    step();
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  task automatic check_pair(input string tag, input logic [DataW-1:0] a,
                            input logic [DataW-1:0] b);
    check_eq({tag, "_valid"}, 32'(m_valid), 32'd1);
    check_eq({tag, "_d1"}, 32'(m_data_1), 32'(a));
    check_eq({tag, "_d2"}, 32'(m_data_2), 32'(b));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
`ifdef FIR_L2_PACK_FLUSH_EN
    flush    = 1'b0;
`endif

    // Reset values
    #12;
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_d1", 32'(m_data_1), 32'd0);
    check_eq("rst_d2", 32'(m_data_2), 32'd0);
    check_eq("rst_count", 32'(pair_count), 32'd0);
    #2 reset_n = 1'b1;
    step();

    // Stream 1,2,3,4 with m_ready high
    s_valid = 1'b1;
    s_data  = 16'd1;
    step();
    check_eq("s1_valid_after_even", 32'(m_valid), 32'd0);
    s_data = 16'd2;
    step();
    check_pair("s1_pair12", 16'd1, 16'd2);
    s_data = 16'd3;
    step();
    check_eq("s1_valid_after_3", 32'(m_valid), 32'd0);
    check_eq("s1_count1", 32'(pair_count), 32'd1);
    s_data = 16'd4;
    step();
    check_pair("s1_pair34", 16'd3, 16'd4);
    s_valid = 1'b0;
    step();
    check_eq("s1_drained", 32'(m_valid), 32'd0);
    check_eq("s1_count2", 32'(pair_count), 32'd2);

    // Continuous stream 10..17: one sample per clock, pairs on alternate cycles
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = DataW'(10 + i);
      #1;
      check_eq($sformatf("cont_s_ready_%0d", i), 32'(s_ready), 32'd1);
      step();
      if (i % 2 == 1) begin
        check_pair($sformatf("cont_pair_%0d", i), DataW'(9 + i), DataW'(10 + i));
      end else begin
        check_eq($sformatf("cont_gap_%0d", i), 32'(m_valid), 32'd0);
      end
    end
    s_valid = 1'b0;
    step();
    check_eq("cont_count", 32'(pair_count), 32'd6);

    // Backpressure: (5,6) pending, 7 accepted, 8 stalls
    m_ready = 1'b0;
    send_pair(16'd5, 16'd6);
    check_pair("bp_pair56", 16'd5, 16'd6);
    s_valid = 1'b1;
    s_data  = 16'd7;
    #1;
    check_eq("bp_accept7", 32'(s_ready), 32'd1);
    step();
    s_data = 16'd8;
    #1;
    check_eq("bp_stall8", 32'(s_ready), 32'd0);
    step();
    check_pair("bp_hold56", 16'd5, 16'd6);
    check_eq("bp_count_hold", 32'(pair_count), 32'd6);
    m_ready = 1'b1;
    #1;
    check_eq("bp_ready_on_drain", 32'(s_ready), 32'd1);
    step();
    check_pair("bp_pair78", 16'd7, 16'd8);
    check_eq("bp_count7", 32'(pair_count), 32'd7);
    s_valid = 1'b0;
    step();
    check_eq("bp_drained", 32'(m_valid), 32'd0);
    check_eq("bp_count8", 32'(pair_count), 32'd8);

    // Counter wrap: 247 more pairs reach all-ones, one more wraps to 0
    for (int i = 0; i < 247; i++) begin
      send_pair(DataW'(2 * i), DataW'(2 * i + 1));
    end
    step();
    check_eq("wrap_allones", 32'(pair_count), 32'd255);
    send_pair(16'h1234, 16'h5678);
    check_pair("wrap_pair", 16'h1234, 16'h5678);
    step();
    check_eq("wrap_zero", 32'(pair_count), 32'd0);
    check_eq("wrap_drained", 32'(m_valid), 32'd0);

`ifdef FIR_L2_PACK_FLUSH_EN
    // Flush: -3 then flush held 3 cycles yields exactly one (-3, 0)
    s_valid = 1'b1;
    s_data  = 16'hFFFD;
    step();
    s_valid = 1'b0;
    flush   = 1'b1;
    step();
    check_pair("fl_pair", 16'hFFFD, 16'h0000);
    step();
    check_eq("fl_once_valid", 32'(m_valid), 32'd0);
    check_eq("fl_count", 32'(pair_count), 32'd1);
    step();
    check_eq("fl_idle_noeffect", 32'(m_valid), 32'd0);
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'd9;
    step();
    check_eq("fl_9_even", 32'(m_valid), 32'd0);
    s_data = 16'd10;
    flush  = 1'b1;
    step();
    check_pair("fl_input_wins", 16'd9, 16'd10);
    s_valid = 1'b0;
    flush   = 1'b0;
    step();
    check_eq("fl_count2", 32'(pair_count), 32'd2);
`endif

    // Asynchronous reset mid-cycle with a pair pending and an even held
    send_pair(16'd30, 16'd31);
    step();
    m_ready = 1'b0;
    send_pair(16'd20, 16'd21);
    s_valid = 1'b1;
    s_data  = 16'd42;
    step();
    s_valid = 1'b0;
    check_pair("ar_pending", 16'd20, 16'd21);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_m_valid", 32'(m_valid), 32'd0);
    check_eq("ar_d1", 32'(m_data_1), 32'd0);
    check_eq("ar_d2", 32'(m_data_2), 32'd0);
    check_eq("ar_count", 32'(pair_count), 32'd0);
    check_eq("ar_s_ready", 32'(s_ready), 32'd1);
    #2 reset_n = 1'b1;
    m_ready = 1'b1;
    step();
    send_pair(16'd1, 16'd2);
    check_pair("ar_fresh_pair", 16'd1, 16'd2);
    step();
    check_eq("ar_count1", 32'(pair_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fir_l2_input_pack.md
# fir_l2_input_pack

Upstream input stage for the L=2 reduced-complexity parallel FIR. It accepts a serial stream of signed samples over a valid/ready handshake and packs consecutive samples into even/odd pairs. Each pair is presented on a registered two-lane output, also with valid/ready. Lane 1 carries x(2k) and drives the filter's `data_in_1` (H0 path). Lane 2 carries x(2k+1) and drives `data_in_2` (H1 path).

## Interface
- `DATA_IN_WIDTH`, 16, sample width; two's complement; must match the FIR input width.
- `CNT_WIDTH`, 16, width of the emitted-pair counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_IN_WIDTH  serial input sample (signed).
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block accepts `s_data` this cycle.
- `m_data_1`  out  DATA_IN_WIDTH  even sample x(2k) (signed, registered).
- `m_data_2`  out  DATA_IN_WIDTH  odd sample x(2k+1) (signed, registered).
- `m_valid`  out  1  output pair is valid.
- `m_ready`  in  1  downstream consumes the pair.
- `pair_count`  out  CNT_WIDTH  number of pairs handed off; wraps modulo 2^CNT_WIDTH.
- `flush`  in  1  present only with `FIR_L2_PACK_FLUSH_EN`; emits a pending half-pair.

## Operation
- Input transfer occurs when `s_valid && s_ready`. Output transfer occurs when `m_valid && m_ready`.
- The state machine `pack_state` has two states, PACK_IDLE and PACK_HALF.
  - **PACK_IDLE:** no even sample held. `s_ready` = 1. On an input transfer, store `s_data` in the even register and go to PACK_HALF.
  - **PACK_HALF:** an even sample is held. `s_ready` = `!m_valid || m_ready`.
    - On an input transfer, load `m_data_1` = even register and `m_data_2` = `s_data`, set `m_valid`, and go to PACK_IDLE.
- Output register rules:
  - `m_valid` clears on an output transfer unless it is reloaded in the same cycle.
  - `m_data_*` hold while `m_valid && !m_ready`.
- `pair_count` increments by 1 on every output transfer. It wraps from all-ones to 0 with no flag.
- Samples pass through unmodified. There is no arithmetic, sign extension or truncation.
- Pairing order is strict. The first sample accepted after reset is always even.
- Reset mid-operation:
  - the state returns to PACK_IDLE;
  - any held even sample is discarded;
  - any pending output pair is discarded (`m_valid` = 0).

## Timing
- Reset values: `s_ready` = 1, `m_valid` = 0, `m_data_1` = 0, `m_data_2` = 0, `pair_count` = 0. The internal even register and state are also cleared (state = PACK_IDLE).
- `s_ready` is combinational from `state`, `m_valid` and `m_ready`. It has no combinational path from `s_valid`.
- Latency: if the odd sample is accepted at edge N, `m_valid` = 1 with that pair from edge N onward.
- Throughput: one sample per clock is sustained while `m_ready` = 1. This gives one pair every two clocks.
- Backpressure: with `m_valid` = 1 and `m_ready` = 0, one further even sample is still accepted into PACK_HALF. After that, `s_ready` = 0 until the output drains.
- Simultaneous output transfer and odd-sample acceptance: the old pair leaves, and the new pair loads at the same edge. `m_valid` stays 1.

## Configuration
- `FIR_L2_PACK_FLUSH_EN` defined:
  - The `flush` port exists.
  - In PACK_HALF, if there is no input transfer this cycle and `!m_valid || m_ready`, the block loads `m_data_1` = even register and `m_data_2` = 0, sets `m_valid`, and goes to PACK_IDLE.
  - An input transfer in the same cycle takes priority, and the flush is ignored.
  - `flush` in PACK_IDLE has no effect.
  - A held-high `flush` acts at most once per half-pair.
- Macro not defined: no `flush` port. A half-pair waits indefinitely for its odd sample.

## Structure
- Shared package `fir_l2_pkg` holds:
  - the `DATA_IN_WIDTH` default constant, shared with the FIR top;
  - `typedef enum logic {PACK_IDLE, PACK_HALF} pack_state_t`.
- No sub-module; the block is a single flat module.

## Test plan
- Reset, then stream 1, 2, 3, 4 with `m_ready` = 1 -> pairs (1,2) then (3,4). `m_valid` rises the edge after 2 and after 4 are accepted; `pair_count` = 2.
- Continuous `s_valid` with values 10..17 and `m_ready` = 1 -> `s_ready` is never low; pairs (10,11), (12,13), (14,15), (16,17) are emitted on alternate cycles.
- Pair (5,6) pending with `m_ready` = 0, then offer 7 and 8 -> 7 is accepted, 8 stalls (`s_ready` = 0); `m_data` holds (5,6). Raising `m_ready` drains (5,6), then (7,8) loads at the edge 8 is accepted.
- Preload `pair_count` to 0xFFFF via 65535 pairs, then one more pair -> `pair_count` = 0.
- With the macro defined: accept -3, then pulse `flush` for 3 cycles -> one pair (-3, 0) and state PACK_IDLE. Next sample 9 is even; sample 9 alongside `flush` in PACK_HALF pairs normally.
- Accept 42, assert `reset_n` = 0 asynchronously mid-cycle -> all outputs go to reset values immediately. After release, 1, 2 -> pair (1,2), not (42,1).
